// File: rtl/wb_arbiter_pkg.sv
// Shared writeback types and constants.
// Used by the arbiter top and its pending-write scoreboard.
package wb_arbiter_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NREG       = 32;
  localparam int CNT_W      = 4;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic            valid;
    reg_addr_t       rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write bit per architectural register.
// Feeds RAW/WAW busy lookups back to the issue stage.
module wb_scoreboard
  import wb_arbiter_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      set_en,
  input  reg_addr_t set_rd,
  input  logic      clr_en,
  input  reg_addr_t clr_rd,
  input  reg_addr_t rs1,
  input  reg_addr_t rs2,
  input  reg_addr_t rd,
  output logic      rs1_busy,
  output logic      rs2_busy,
  output logic      rd_busy
);

  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;

  // Set after clear: a newly issued producer owns the register.
  always_comb begin
    pending_nxt = pending;
    if (clr_en) begin
      pending_nxt[clr_rd] = 1'b0;
    end
    if (set_en && (set_rd != '0)) begin
      pending_nxt[set_rd] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  function automatic logic lookup(
    input logic [NREG-1:0] pend,
    input logic            wen,
    input reg_addr_t       waddr,
    input reg_addr_t       x
  );
    return (x != '0) & pend[x] & ~(wen & (waddr == x));
  endfunction

  // The RF forwards the write in flight, so it reads not-busy.
  assign rs1_busy = lookup(pending, clr_en, clr_rd, rs1);
  assign rs2_busy = lookup(pending, clr_en, clr_rd, rs2);
  assign rd_busy  = lookup(pending, clr_en, clr_rd, rd);

endmodule

// File: rtl/wb_arbiter.sv
// Writeback stage: merges pipe and MDU results into one
// registered RF write per cycle, with an anti-starvation grant.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN         = wb_arbiter_pkg::XLEN,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pipe_valid,
  output logic                  pipe_ready,
  input  logic [REG_ADDR_W-1:0] pipe_rd,
  input  logic [XLEN-1:0]       pipe_data,
  input  logic                  mdu_valid,
  output logic                  mdu_ready,
  input  logic [REG_ADDR_W-1:0] mdu_rd,
  input  logic [XLEN-1:0]       mdu_data,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_rd,
  input  logic [REG_ADDR_W-1:0] iss_rs1,
  input  logic [REG_ADDR_W-1:0] iss_rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rd_busy,
  output logic                  rf_wen,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  wb_req_t          pipe_req;
  wb_req_t          mdu_req;
  wb_req_t          win;
  logic             grant_mdu;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_nxt;

  assign pipe_req.valid = pipe_valid;
  assign pipe_req.rd    = pipe_rd;
  assign pipe_req.data  = pipe_data;
  assign mdu_req.valid  = mdu_valid;
  assign mdu_req.rd     = mdu_rd;
  assign mdu_req.data   = mdu_data;

  // The pipe wins ties until the MDU has waited STARVE_LIMIT cycles.
  assign grant_mdu  = mdu_req.valid
                    & (~pipe_req.valid | (starve_cnt == LIMIT));
  assign mdu_ready  = grant_mdu;
  assign pipe_ready = ~grant_mdu;

  // win.valid is exactly "some source handshakes this cycle".
  assign win = grant_mdu ? mdu_req : pipe_req;

  always_comb begin
    starve_nxt = starve_cnt;
    if (!mdu_valid || grant_mdu) begin
      starve_nxt = '0;
    end else if (starve_cnt != LIMIT) begin
      starve_nxt = starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_wen <= win.valid & (win.rd != '0);
      if (win.valid) begin
        rf_waddr <= win.rd;
        rf_wdata <= win.data;
      end
    end
  end

  wb_scoreboard u_sb (
    .clock    (clock),
    .reset    (reset),
    .set_en   (iss_valid),
    .set_rd   (iss_rd),
    .clr_en   (rf_wen),
    .clr_rd   (rf_waddr),
    .rs1      (iss_rs1),
    .rs2      (iss_rs2),
    .rd       (iss_rd),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy)
  );

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: directed scenarios then
// randomized producer/issue traffic against a reference model.
module tb_wb_arbiter;

  localparam int XLEN = 64;
  localparam int LIM  = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            pipe_valid, pipe_ready;
  logic [4:0]      pipe_rd;
  logic [XLEN-1:0] pipe_data;
  logic            mdu_valid, mdu_ready;
  logic [4:0]      mdu_rd;
  logic [XLEN-1:0] mdu_data;
  logic            iss_valid;
  logic [4:0]      iss_rd, iss_rs1, iss_rs2;
  logic            rs1_busy, rs2_busy, rd_busy;
  logic            rf_wen;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  always #5 clock = ~clock;

  wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIM)) dut (
    .clock(clock), .reset(reset),
    .pipe_valid(pipe_valid), .pipe_ready(pipe_ready),
    .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
    .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  typedef struct {
    int              cyc;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wr_t;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } res_t;

  wr_t  exp_q[$];
  res_t pq[$];
  res_t mq[$];

  int         tests = 0;
  int         fails = 0;
  int         cyc   = 0;
  bit         m_pend[32];
  bit         m_wen;
  logic [4:0] m_waddr;
  int         m_refused;
  bit         acc_p, acc_m;
  bit         pv_on, mv_on;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic bit mbusy(input logic [4:0] x);
    return (x != 0) && m_pend[x] && !(m_wen && m_waddr == x);
  endfunction

  task automatic mreset();
    exp_q.delete();
    pq.delete();
    mq.delete();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_wen     = 1'b0;
    m_waddr   = '0;
    m_refused = 0;
    pv_on     = 1'b0;
    mv_on     = 1'b0;
  endtask

  task automatic clr();
    pipe_valid = 0; pipe_rd = '0; pipe_data = '0;
    mdu_valid  = 0; mdu_rd  = '0; mdu_data  = '0;
    iss_valid  = 0; iss_rd  = '0;
    iss_rs1    = '0; iss_rs2 = '0;
  endtask

  // Called just after a negedge with inputs driven; ends on the next negedge.
  task automatic step();
    bit              g, hs;
    logic [4:0]      wrd;
    logic [XLEN-1:0] wd;
    #1;
    g = mdu_valid && (!pipe_valid || m_refused >= LIM);
    chk("mdu_ready", mdu_ready, g);
    chk("pipe_ready", pipe_ready, !g);
    chk("rs1_busy", rs1_busy, mbusy(iss_rs1));
    chk("rs2_busy", rs2_busy, mbusy(iss_rs2));
    chk("rd_busy", rd_busy, mbusy(iss_rd));
    if (pipe_valid && pipe_rd != 0)
      chk("pipe_rd_pending", m_pend[pipe_rd], 1);
    if (mdu_valid && mdu_rd != 0)
      chk("mdu_rd_pending", m_pend[mdu_rd], 1);
    hs  = g || pipe_valid;
    wrd = g ? mdu_rd : pipe_rd;
    wd  = g ? mdu_data : pipe_data;
    if (hs && wrd != 0)
      exp_q.push_back('{cyc: cyc + 1, rd: wrd, data: wd});
    if (m_wen) m_pend[m_waddr] = 1'b0;
    if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1'b1;
    m_wen = hs && wrd != 0;
    if (hs) m_waddr = wrd;
    m_refused = (!mdu_valid || g) ? 0 : m_refused + 1;
    acc_p = pipe_valid && !g;
    acc_m = g;
    @(negedge clock);
  endtask

  task automatic rand_cycle(input bit allow_iss);
    res_t r;
    clr();
    iss_rs1 = 5'($urandom);
    iss_rs2 = 5'($urandom);
    if (!pv_on && pq.size() > 0 && $urandom_range(0, 3) != 0) pv_on = 1;
    if (!mv_on && mq.size() > 0 && $urandom_range(0, 2) == 0) mv_on = 1;
    pipe_valid = pv_on;
    if (pv_on) begin pipe_rd = pq[0].rd; pipe_data = pq[0].data; end
    mdu_valid = mv_on;
    if (mv_on) begin mdu_rd = mq[0].rd; mdu_data = mq[0].data; end
    iss_rd    = 5'($urandom);
    iss_valid = allow_iss && ($urandom_range(0, 3) != 0)
              && !mbusy(iss_rd) && (pq.size() + mq.size() < 8);
    step();
    if (acc_p) begin void'(pq.pop_front()); pv_on = 0; end
    if (acc_m) begin void'(mq.pop_front()); mv_on = 0; end
    if (iss_valid) begin
      r.rd   = iss_rd;
      r.data = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) mq.push_back(r);
      else pq.push_back(r);
    end
  endtask

  task automatic issue(input logic [4:0] rd);
    clr(); iss_valid = 1; iss_rd = rd; step();
  endtask

  // Monitor: every registered RF write must match the oldest expectation.
  wr_t e;
  bit  exp_w;
  always @(posedge clock) begin
    #1;
    cyc++;
    if (reset) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        tests++; fails++;
        $display("FAIL missed_write: x%0d got none expected at cycle %0d",
                 exp_q[0].rd, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      exp_w = exp_q.size() > 0 && exp_q[0].cyc == cyc;
      chk("rf_wen", rf_wen, exp_w);
      if (exp_w) begin
        e = exp_q.pop_front();
        chk("rf_waddr", rf_waddr, e.rd);
        chk("rf_wdata", rf_wdata, e.data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pidx, k, grant_k, n;
    bit mdone;
    clr();
    mreset();
    @(negedge clock);
    @(negedge clock);
    chk("reset_rf_wen", rf_wen, 0);
    chk("reset_rf_waddr", rf_waddr, 0);
    chk("reset_rf_wdata", rf_wdata, 0);
    reset = 1;

    // Single pipe result
    issue(5'd3);
    clr(); pipe_valid = 1; pipe_rd = 3; pipe_data = 64'h1234; step();
    clr(); step();
    clr(); step();

    // Contention and starvation
    issue(5'd7);
    for (int i = 0; i < 5; i++) issue(5'(20 + i));
    pidx = 0; mdone = 0; k = 0; grant_k = -1;
    while ((pidx < 5 || !mdone) && k < 20) begin
      clr();
      pipe_valid = (pidx < 5);
      pipe_rd    = 5'(20 + pidx);
      pipe_data  = 64'(100 + pidx);
      mdu_valid  = !mdone;
      mdu_rd     = 7;
      mdu_data   = 64'hABCD;
      step();
      if (acc_p) pidx++;
      if (acc_m) begin mdone = 1; grant_k = k; end
      k++;
    end
    chk("starve_grant_cycle", grant_k, LIM);

    // rd=0 discard
    clr(); mdu_valid = 1; mdu_rd = 0; mdu_data = 64'hFFFF; step();
    clr(); step();

    // Scoreboard RAW on x9
    issue(5'd9);
    clr(); iss_rs1 = 9; step();
    clr(); iss_rs1 = 9; step();
    clr(); iss_rs1 = 9; pipe_valid = 1; pipe_rd = 9;
    pipe_data = 64'h99; step();
    clr(); iss_rs1 = 9; step();
    clr(); iss_rs1 = 9; step();

    // Set/clear collision on x12
    issue(5'd12);
    clr(); pipe_valid = 1; pipe_rd = 12; pipe_data = 64'h55; step();
    clr(); iss_valid = 1; iss_rd = 12; step();
    clr(); iss_rd = 12; iss_rs2 = 12; step();
    chk("collision_rd_busy", rd_busy, 1);
    clr(); pipe_valid = 1; pipe_rd = 12; pipe_data = 64'h56; step();
    clr(); step();

    // Reset mid-traffic
    issue(5'd5);
    issue(5'd6);
    clr(); pipe_valid = 1; pipe_rd = 5; pipe_data = 64'h77;
    iss_rd = 6; iss_rs1 = 5;
    #2;
    reset = 0;
    #1;
    chk("midreset_rf_wen", rf_wen, 0);
    chk("midreset_rf_waddr", rf_waddr, 0);
    chk("midreset_rf_wdata", rf_wdata, 0);
    chk("midreset_rd_busy", rd_busy, 0);
    chk("midreset_rs1_busy", rs1_busy, 0);
    mreset();
    @(negedge clock);
    reset = 1;
    clr();
    for (int i = 0; i < 3; i++) step();

    // Randomized traffic, then drain
    for (int i = 0; i < 3000; i++) rand_cycle(1);
    n = 0;
    while ((pq.size() > 0 || mq.size() > 0) && n < 400) begin
      rand_cycle(0);
      n++;
    end
    chk("drain_producers", pq.size() + mq.size(), 0);
    clr();
    for (int i = 0; i < 3; i++) step();
    chk("exp_q_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
